// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, load/store funct3 encodings,
// the memory-stage FSM state type and the store-lane helpers.
package riscv_pkg;

  localparam int REG_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  // funct3[1:0] is the access size; unused size encodings are treated as words.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic r;
    case (funct3[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] r;
    case (funct3[1:0])
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = 4'b0011 << off;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [REG_WIDTH-1:0] store_data(input logic [2:0] funct3,
                                                      input logic [REG_WIDTH-1:0] data);
    logic [REG_WIDTH-1:0] r;
    case (funct3[1:0])
      2'b00:   r = {4{data[7:0]}};
      2'b01:   r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load response word and sign- or
// zero-extends it to the register width.
module load_align
  import riscv_pkg::*;
(
  input  logic [REG_WIDTH-1:0] i_dmem_rdata,
  input  logic [1:0]           i_addr_lo,
  input  logic [2:0]           i_funct3,
  output logic [REG_WIDTH-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0: w_byte = i_dmem_rdata[7:0];
      2'd1: w_byte = i_dmem_rdata[15:8];
      2'd2: w_byte = i_dmem_rdata[23:16];
      2'd3: w_byte = i_dmem_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_addr_lo[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
  end

  always_comb begin
    o_result = i_dmem_rdata;
    case (i_funct3)
      F3_B:    o_result = {{(REG_WIDTH-8){w_byte[7]}}, w_byte};
      F3_H:    o_result = {{(REG_WIDTH-16){w_half[15]}}, w_half};
      F3_BU:   o_result = {{(REG_WIDTH-8){1'b0}}, w_byte};
      F3_HU:   o_result = {{(REG_WIDTH-16){1'b0}}, w_half};
      default: o_result = i_dmem_rdata;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: issues data-memory requests, stalls while an access is in
// flight, aligns load data and registers the MEM/WB fields.
module stage_mem #(
  parameter int REG_WIDTH = riscv_pkg::REG_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 EX_MEM_valid,
  input  logic [REG_WIDTH-1:0] EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0] EX_MEM_store_data,
  input  logic                 EX_MEM_mem_read,
  input  logic                 EX_MEM_mem_write,
  input  logic [2:0]           EX_MEM_funct3,
  input  logic [4:0]           EX_MEM_rd,
  input  logic                 EX_MEM_reg_write_en,
  output logic                 dmem_req_valid,
  input  logic                 dmem_req_ready,
  output logic [REG_WIDTH-1:0] dmem_addr,
  output logic                 dmem_we,
  output logic [REG_WIDTH-1:0] dmem_wdata,
  output logic [3:0]           dmem_wstrb,
  input  logic                 dmem_rsp_valid,
  input  logic [REG_WIDTH-1:0] dmem_rdata,
  output logic                 mem_stall,
  output logic                 MEM_WB_valid,
  output logic [REG_WIDTH-1:0] MEM_WB_alu_out,
  output logic                 MEM_WB_reg_wb_sel,
  output logic [4:0]           MEM_WB_rd,
  output logic                 MEM_WB_reg_write_en,
  output logic                 MEM_WB_misalign
);

  import riscv_pkg::*;

  mem_state_t           r_state;
  logic                 r_req_valid;
  logic [REG_WIDTH-1:0] r_addr;
  logic                 r_we;
  logic [REG_WIDTH-1:0] r_wdata;
  logic [3:0]           r_wstrb;
  logic [1:0]           r_ld_off;
  logic [2:0]           r_ld_funct3;

  logic                 w_is_mem;
  logic                 w_misalign;
  logic                 w_start;
  logic [REG_WIDTH-1:0] w_load_result;

  assign w_is_mem   = EX_MEM_mem_read | EX_MEM_mem_write;
  assign w_misalign = EX_MEM_valid & w_is_mem & is_misaligned(EX_MEM_funct3, EX_MEM_alu_out[1:0]);
  assign w_start    = EX_MEM_valid & w_is_mem & ~w_misalign;

  assign dmem_req_valid = r_req_valid;
  assign dmem_addr      = r_addr;
  assign dmem_we        = r_we;
  assign dmem_wdata     = r_wdata;
  assign dmem_wstrb     = r_wstrb;

  load_align u_load_align (
    .i_dmem_rdata (dmem_rdata),
    .i_addr_lo    (r_ld_off),
    .i_funct3     (r_ld_funct3),
    .o_result     (w_load_result)
  );

  // A store releases the pipeline in the same cycle it is accepted.
  always_comb begin
    mem_stall = 1'b0;
    case (r_state)
      IDLE:    mem_stall = w_start;
      REQ:     mem_stall = ~(dmem_req_ready & r_we);
      WAIT:    mem_stall = ~dmem_rsp_valid;
      default: mem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_req_valid <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= 4'b0000;
      r_ld_off    <= 2'b00;
      r_ld_funct3 <= 3'b000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= REQ;
            r_req_valid <= 1'b1;
            r_addr      <= {EX_MEM_alu_out[REG_WIDTH-1:2], 2'b00};
            r_we        <= EX_MEM_mem_write;
            r_wdata     <= EX_MEM_mem_write ? store_data(EX_MEM_funct3, EX_MEM_store_data) : '0;
            r_wstrb     <= EX_MEM_mem_write ? store_strb(EX_MEM_funct3, EX_MEM_alu_out[1:0]) : 4'b0000;
            r_ld_off    <= EX_MEM_alu_out[1:0];
            r_ld_funct3 <= EX_MEM_funct3;
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= r_we ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (dmem_rsp_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Completing loads are the only entries that leave the stage from WAIT.
  always_ff @(posedge clk) begin
    if (!reset_n || mem_stall || !EX_MEM_valid) begin
      MEM_WB_valid        <= 1'b0;
      MEM_WB_alu_out      <= '0;
      MEM_WB_reg_wb_sel   <= 1'b0;
      MEM_WB_rd           <= 5'd0;
      MEM_WB_reg_write_en <= 1'b0;
      MEM_WB_misalign     <= 1'b0;
    end else begin
      MEM_WB_valid        <= 1'b1;
      MEM_WB_alu_out      <= (r_state == WAIT) ? w_load_result : EX_MEM_alu_out;
      MEM_WB_reg_wb_sel   <= (r_state == WAIT);
      MEM_WB_rd           <= EX_MEM_rd;
      MEM_WB_reg_write_en <= EX_MEM_reg_write_en & ~w_misalign;
      MEM_WB_misalign     <= w_misalign;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: table of single-cycle ops plus hand-written
// load, store and reset sequences with hand-computed expectations.
module tb_stage_mem;

  logic        clk;
  logic        reset_n;
  logic        EX_MEM_valid;
  logic [31:0] EX_MEM_alu_out;
  logic [31:0] EX_MEM_store_data;
  logic        EX_MEM_mem_read;
  logic        EX_MEM_mem_write;
  logic [2:0]  EX_MEM_funct3;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_reg_write_en;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        MEM_WB_valid;
  logic [31:0] MEM_WB_alu_out;
  logic        MEM_WB_reg_wb_sel;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_reg_write_en;
  logic        MEM_WB_misalign;

  int checks;
  int failures;

  stage_mem dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .EX_MEM_valid        (EX_MEM_valid),
    .EX_MEM_alu_out      (EX_MEM_alu_out),
    .EX_MEM_store_data   (EX_MEM_store_data),
    .EX_MEM_mem_read     (EX_MEM_mem_read),
    .EX_MEM_mem_write    (EX_MEM_mem_write),
    .EX_MEM_funct3       (EX_MEM_funct3),
    .EX_MEM_rd           (EX_MEM_rd),
    .EX_MEM_reg_write_en (EX_MEM_reg_write_en),
    .dmem_req_valid      (dmem_req_valid),
    .dmem_req_ready      (dmem_req_ready),
    .dmem_addr           (dmem_addr),
    .dmem_we             (dmem_we),
    .dmem_wdata          (dmem_wdata),
    .dmem_wstrb          (dmem_wstrb),
    .dmem_rsp_valid      (dmem_rsp_valid),
    .dmem_rdata          (dmem_rdata),
    .mem_stall           (mem_stall),
    .MEM_WB_valid        (MEM_WB_valid),
    .MEM_WB_alu_out      (MEM_WB_alu_out),
    .MEM_WB_reg_wb_sel   (MEM_WB_reg_wb_sel),
    .MEM_WB_rd           (MEM_WB_rd),
    .MEM_WB_reg_write_en (MEM_WB_reg_write_en),
    .MEM_WB_misalign     (MEM_WB_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic        mrd;
    logic        mwr;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        wen;
    logic        eValid;
    logic [31:0] eAlu;
    logic [4:0]  eRd;
    logic        eWen;
    logic        eMis;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] alu, input logic [31:0] sdata,
                               input logic mrd, input logic mwr, input logic [2:0] f3,
                               input logic [4:0] rd, input logic wen);
    EX_MEM_valid        = valid;
    EX_MEM_alu_out      = alu;
    EX_MEM_store_data   = sdata;
    EX_MEM_mem_read     = mrd;
    EX_MEM_mem_write    = mwr;
    EX_MEM_funct3       = f3;
    EX_MEM_rd           = rd;
    EX_MEM_reg_write_en = wen;
  endtask

  task automatic checkBubble(input string name);
    checkOutput({name, ".valid"}, {31'd0, MEM_WB_valid}, 32'd0);
    checkOutput({name, ".wen"}, {31'd0, MEM_WB_reg_write_en}, 32'd0);
  endtask

  task automatic runLoad(input string name, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input int delay, input logic [31:0] expected);
    applyStimulus(1'b1, addr, 32'h0, 1'b1, 1'b0, f3, 5'd10, 1'b1);
    @(negedge clk);
    checkOutput({name, ".idleStall"}, {31'd0, mem_stall}, 32'd1);
    checkOutput({name, ".idleReq"}, {31'd0, dmem_req_valid}, 32'd0);
    @(posedge clk); #1;
    checkBubble({name, ".b0"});
    checkOutput({name, ".reqValid"}, {31'd0, dmem_req_valid}, 32'd1);
    checkOutput({name, ".addr"}, dmem_addr, {addr[31:2], 2'b00});
    checkOutput({name, ".we"}, {31'd0, dmem_we}, 32'd0);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    checkOutput({name, ".reqStall"}, {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    checkOutput({name, ".reqDrop"}, {31'd0, dmem_req_valid}, 32'd0);
    checkBubble({name, ".b1"});
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checkOutput({name, ".waitStall"}, {31'd0, mem_stall}, 32'd1);
      @(posedge clk); #1;
      checkBubble({name, ".bw"});
    end
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = rdata;
    @(negedge clk);
    checkOutput({name, ".rspStall"}, {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    checkOutput({name, ".valid"}, {31'd0, MEM_WB_valid}, 32'd1);
    checkOutput({name, ".data"}, MEM_WB_alu_out, expected);
    checkOutput({name, ".wbSel"}, {31'd0, MEM_WB_reg_wb_sel}, 32'd1);
    checkOutput({name, ".rd"}, {27'd0, MEM_WB_rd}, 32'd10);
    checkOutput({name, ".wen"}, {31'd0, MEM_WB_reg_write_en}, 32'd1);
    @(posedge clk); #1;
    checkBubble({name, ".after"});
  endtask

  task automatic runStore(input string name, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] data, input int waitCycles, input logic [31:0] eAddr,
                          input logic [3:0] eStrb, input logic [31:0] eData);
    int stallCount;
    stallCount = 0;
    applyStimulus(1'b1, addr, data, 1'b0, 1'b1, f3, 5'd0, 1'b0);
    @(negedge clk);
    if (mem_stall) stallCount++;
    checkOutput({name, ".idleReq"}, {31'd0, dmem_req_valid}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i <= waitCycles; i++) begin
      if (i == waitCycles) dmem_req_ready = 1'b1;
      @(negedge clk);
      if (mem_stall) stallCount++;
      checkOutput({name, ".reqValid"}, {31'd0, dmem_req_valid}, 32'd1);
      checkOutput({name, ".addr"}, dmem_addr, eAddr);
      checkOutput({name, ".strb"}, {28'd0, dmem_wstrb}, {28'd0, eStrb});
      checkOutput({name, ".wdata"}, dmem_wdata, eData);
      checkOutput({name, ".we"}, {31'd0, dmem_we}, 32'd1);
      @(posedge clk); #1;
      if (i < waitCycles) checkBubble({name, ".bw"});
    end
    dmem_req_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    checkOutput({name, ".stallCycles"}, stallCount, waitCycles + 1);
    checkOutput({name, ".valid"}, {31'd0, MEM_WB_valid}, 32'd1);
    checkOutput({name, ".alu"}, MEM_WB_alu_out, addr);
    checkOutput({name, ".wbSel"}, {31'd0, MEM_WB_reg_wb_sel}, 32'd0);
    checkOutput({name, ".reqDone"}, {31'd0, dmem_req_valid}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n        = 1'b0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);

    //           valid alu           mrd   mwr   f3      rd     wen   eValid eAlu          eRd    eWen  eMis
    vecs[0] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 3'b000, 5'd5,  1'b1, 1'b1, 32'h0000_1234, 5'd5,  1'b1, 1'b0};
    vecs[1] = '{1'b0, 32'h5555_5555, 1'b0, 1'b0, 3'b000, 5'd9,  1'b1, 1'b0, 32'h0,         5'd0,  1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0202, 1'b1, 1'b0, 3'b010, 5'd7,  1'b1, 1'b1, 32'h0000_0202, 5'd7,  1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'b010, 5'd31, 1'b0, 1'b1, 32'hDEAD_BEEF, 5'd31, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0105, 1'b1, 1'b0, 3'b101, 5'd3,  1'b1, 1'b1, 32'h0000_0105, 5'd3,  1'b0, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0101, 1'b0, 1'b1, 3'b001, 5'd0,  1'b0, 1'b1, 32'h0000_0101, 5'd0,  1'b0, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_0042, 1'b0, 1'b0, 3'b000, 5'd1,  1'b1, 1'b1, 32'h0000_0042, 5'd1,  1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.valid", {31'd0, MEM_WB_valid}, 32'd0);
    checkOutput("rst.alu", MEM_WB_alu_out, 32'd0);
    checkOutput("rst.rd", {27'd0, MEM_WB_rd}, 32'd0);
    checkOutput("rst.wen", {31'd0, MEM_WB_reg_write_en}, 32'd0);
    checkOutput("rst.mis", {31'd0, MEM_WB_misalign}, 32'd0);
    checkOutput("rst.req", {31'd0, dmem_req_valid}, 32'd0);
    checkOutput("rst.stall", {31'd0, mem_stall}, 32'd0);
    reset_n = 1'b1;

    // Spurious ready is held high across the table; it must not start anything.
    dmem_req_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].alu, 32'h0, vecs[i].mrd, vecs[i].mwr,
                    vecs[i].f3, vecs[i].rd, vecs[i].wen);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.stall", i), {31'd0, mem_stall}, 32'd0);
      checkOutput($sformatf("vec%0d.req", i), {31'd0, dmem_req_valid}, 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d.valid", i), {31'd0, MEM_WB_valid}, {31'd0, vecs[i].eValid});
      checkOutput($sformatf("vec%0d.alu", i), MEM_WB_alu_out, vecs[i].eAlu);
      checkOutput($sformatf("vec%0d.wbSel", i), {31'd0, MEM_WB_reg_wb_sel}, 32'd0);
      checkOutput($sformatf("vec%0d.rd", i), {27'd0, MEM_WB_rd}, {27'd0, vecs[i].eRd});
      checkOutput($sformatf("vec%0d.wen", i), {31'd0, MEM_WB_reg_write_en}, {31'd0, vecs[i].eWen});
      checkOutput($sformatf("vec%0d.mis", i), {31'd0, MEM_WB_misalign}, {31'd0, vecs[i].eMis});
    end
    dmem_req_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    @(posedge clk); #1;

    runLoad("lb",  32'h0000_0103, 3'b000, 32'h80FF_0000, 0, 32'hFFFF_FF80);
    runLoad("lbu", 32'h0000_0103, 3'b100, 32'h80FF_0000, 0, 32'h0000_0080);
    runLoad("lbp", 32'h0000_0101, 3'b000, 32'h0000_7F00, 1, 32'h0000_007F);
    runLoad("lh",  32'h0000_0102, 3'b001, 32'h80FF_0000, 2, 32'hFFFF_80FF);
    runLoad("lhu", 32'h0000_0100, 3'b101, 32'h1234_8001, 0, 32'h0000_8001);
    runLoad("lhs", 32'h0000_0100, 3'b001, 32'h1234_8001, 0, 32'hFFFF_8001);
    runLoad("lw",  32'h0000_0200, 3'b010, 32'h1234_5678, 5, 32'h1234_5678);

    runStore("sh", 32'h0000_0102, 3'b001, 32'h0000_ABCD, 3, 32'h0000_0100, 4'b1100, 32'hABCD_ABCD);
    runStore("sb", 32'h0000_0101, 3'b000, 32'h1234_5678, 0, 32'h0000_0100, 4'b0010, 32'h7878_7878);
    runStore("sw", 32'h0000_0204, 3'b010, 32'hCAFE_F00D, 1, 32'h0000_0204, 4'b1111, 32'hCAFE_F00D);

    // Reset while waiting for a load response, then a stray response.
    applyStimulus(1'b1, 32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd12, 1'b1);
    @(posedge clk); #1;
    dmem_req_ready = 1'b1;
    @(posedge clk); #1;
    dmem_req_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstWait.stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("rstWait.valid", {31'd0, MEM_WB_valid}, 32'd0);
    checkOutput("rstWait.stall0", {31'd0, mem_stall}, 32'd0);
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'hDEAD_0001;
    @(negedge clk);
    checkOutput("spur.stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    dmem_rsp_valid = 1'b0;
    checkOutput("spur.valid", {31'd0, MEM_WB_valid}, 32'd0);
    checkOutput("spur.wen", {31'd0, MEM_WB_reg_write_en}, 32'd0);
    checkOutput("spur.alu", MEM_WB_alu_out, 32'd0);

    // Reset while a request is pending must drop dmem_req_valid.
    applyStimulus(1'b1, 32'h0000_0400, 32'h0000_0011, 1'b0, 1'b1, 3'b010, 5'd0, 1'b0);
    @(posedge clk); #1;
    checkOutput("rstReq.pending", {31'd0, dmem_req_valid}, 32'd1);
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'b000, 5'd0, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    checkOutput("rstReq.req", {31'd0, dmem_req_valid}, 32'd0);
    checkOutput("rstReq.strb", {28'd0, dmem_wstrb}, 32'd0);
    checkOutput("rstReq.stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rstReq.valid", {31'd0, MEM_WB_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
# stage_mem

Memory-access pipeline stage of the RISC-V core, sitting between the EX/MEM and MEM/WB pipeline registers. It issues loads and stores to data memory over a valid/ready request and valid response handshake, and stalls the pipeline while an access is outstanding. It aligns and extends load data, then registers the MEM/WB fields consumed by the writeback stage.

## Interface
- REG_WIDTH, 32, datapath width; only 32 is supported.

- clk  in  1  clock; single clock domain.
- reset_n  in  1  synchronous, active-low reset.
- EX_MEM_valid  in  1  EX/MEM entry holds a real instruction.
- EX_MEM_alu_out  in  REG_WIDTH  ALU result; the effective address for memory ops.
- EX_MEM_store_data  in  REG_WIDTH  rs2 value for stores.
- EX_MEM_mem_read  in  1  instruction is a load.
- EX_MEM_mem_write  in  1  instruction is a store.
- EX_MEM_funct3  in  3  access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- EX_MEM_rd  in  5  destination register.
- EX_MEM_reg_write_en  in  1  instruction writes rd.
- dmem_req_valid  out  1  request valid.
- dmem_req_ready  in  1  memory accepts the request.
- dmem_addr  out  REG_WIDTH  word-aligned address (addr[1:0]=0).
- dmem_we  out  1  1 = store.
- dmem_wdata  out  REG_WIDTH  store data replicated across lanes.
- dmem_wstrb  out  4  byte enables.
- dmem_rsp_valid  in  1  load data valid.
- dmem_rdata  in  REG_WIDTH  load data word.
- mem_stall  out  1  hold the IF/ID/EX stages and the EX/MEM register.
- MEM_WB_valid  out  1  MEM/WB entry valid.
- MEM_WB_alu_out  out  REG_WIDTH  load result when a load, otherwise the ALU result.
- MEM_WB_reg_wb_sel  out  1  1 when MEM_WB_alu_out holds load data.
- MEM_WB_rd  out  5  destination register.
- MEM_WB_reg_write_en  out  1  register write enable.
- MEM_WB_misalign  out  1  misaligned-access flag; a one-entry pulse.

## Operation
- FSM states are IDLE, REQ and WAIT.
- **IDLE**
  - If EX_MEM_valid is set and (mem_read or mem_write) is set and the access is aligned: go to REQ, mem_stall=1.
  - Otherwise stay in IDLE, mem_stall=0.
- **REQ**
  - dmem_req_valid=1 with address, data and strobes held stable until dmem_req_ready.
  - On ready for a store: go to IDLE, mem_stall=0 in that cycle.
  - On ready for a load: go to WAIT, mem_stall=1.
  - Without ready: stay in REQ, mem_stall=1.
- **WAIT**
  - mem_stall = !dmem_rsp_valid.
  - On dmem_rsp_valid: go to IDLE.
- **MEM/WB update**, each edge:
  - With mem_stall=0: load a bubble if EX_MEM_valid=0, otherwise the EX/MEM fields.
  - With mem_stall=1: load a bubble (valid=0, reg_write_en=0, misalign=0).
- **Alignment**
  - H is misaligned when addr[0]=1.
  - W is misaligned when addr[1:0]≠0.
  - A misaligned op issues no request and does not stall.
  - MEM/WB then gets misalign=1, reg_write_en=0, valid=1.
- **Store lanes**
  - SB: wstrb = 0001<<addr[1:0], wdata = {4{data[7:0]}}.
  - SH: wstrb = 0011<<addr[1:0], wdata = {2{data[15:0]}}.
  - SW: wstrb = 1111.
- **Load extract**
  - The byte or halfword is selected by addr[1:0] from dmem_rdata.
  - B and H are sign-extended; BU and HU are zero-extended.
  - reg_wb_sel=1 for loads.
- A dmem_rsp_valid arriving in IDLE or REQ is ignored.
- A dmem_req_ready arriving outside REQ is ignored.

## Timing
- **Reset** (reset_n low at an edge):
  - state=IDLE.
  - All MEM_WB_* outputs are 0.
  - dmem_req_valid is 0 from the next cycle.
  - The request registers are cleared.
- **Store latency:** one request cycle beyond the IDLE detect; with ready in the first REQ cycle, the stall lasts exactly 1 cycle.
- **Load latency:** at least 2 stall cycles (IDLE→REQ→WAIT); MEM/WB is loaded on the edge ending the cycle in which dmem_rsp_valid is seen.
- **Non-memory op:** 1-cycle MEM/WB latency, no stall.
- **Outputs:** dmem_* come from registers captured at the IDLE→REQ transition. mem_stall is combinational from state and inputs.
- **Reset mid-access:** abandons the access; no MEM/WB entry is produced for it.

## Structure
- Shared riscv_pkg holds:
  - funct3 load/store encodings;
  - the FSM state enum {IDLE, REQ, WAIT};
  - the REG_WIDTH constant.
- Sub-module load_align (combinational): inputs dmem_rdata, addr[1:0] and funct3; output is the extended REG_WIDTH result.

## Test plan
- ADD result 0x0000_1234, rd=5 → MEM_WB_alu_out=0x1234, reg_wb_sel=0, rd=5 one edge later, mem_stall never set.
- LB addr 0x103, rdata 0x80FF_0000 → result 0xFFFF_FF80, reg_wb_sel=1; LBU on the same access → 0x0000_0080.
- SH addr 0x102, data 0x0000_ABCD, ready held low 3 cycles → req_valid, addr 0x100 and wstrb 1100 stable throughout, wdata 0xABCD_ABCD, mem_stall high 4 cycles.
- LW addr 0x202 → no dmem_req_valid, MEM_WB_misalign=1, reg_write_en=0, no stall.
- LW with rsp delayed 5 cycles → MEM/WB bubbles during the stall, then one valid entry with rdata.
- reset_n low while in WAIT → IDLE and MEM_WB cleared; a later spurious rsp_valid produces no MEM/WB entry.
